// File: rtl/mycpu_pkg.sv
// Shared types for the mycpu control unit: function-select codes, sequencer
// states, instruction classes and instruction field positions.
package mycpu_pkg;

    typedef enum logic [3:0] {
        MOVA   = 4'h0,
        INC    = 4'h1,
        FADD   = 4'h2,
        FADDC  = 4'h3,
        FADDNB = 4'h4,
        FSUB   = 4'h5,
        DEC    = 4'h6,
        FAND   = 4'h8,
        FOR    = 4'h9,
        FXOR   = 4'hA,
        FNOT   = 4'hB,
        MOVB   = 4'hC,
        SHR    = 4'hD,
        SHL    = 4'hE
    } fs_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_LOAD   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU  = 3'b000,
        CL_ALUI = 3'b001,
        CL_LD   = 3'b010,
        CL_ST   = 3'b011,
        CL_BRZ  = 3'b100,
        CL_BRN  = 3'b101,
        CL_JMP  = 3'b110,
        CL_HALT = 3'b111
    } class_t;

    localparam int CLASS_MSB = 15;
    localparam int CLASS_LSB = 13;
    localparam int FS_MSB    = 12;
    localparam int FS_LSB    = 9;
    localparam int DR_MSB    = 8;
    localparam int DR_LSB    = 6;
    localparam int SA_MSB    = 5;
    localparam int SA_LSB    = 3;
    localparam int SB_MSB    = 2;
    localparam int SB_LSB    = 0;
    localparam int OFF_MSB   = 8;

    // Branch offset occupies [8:0]; widen to PC width keeping the sign.
    function automatic logic [15:0] sext_off9(input logic [15:0] ir);
        return {{(15 - OFF_MSB){ir[OFF_MSB]}}, ir[OFF_MSB:0]};
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational instruction-field decode: drives datapath controls from the
// held instruction, only while the sequencer is in EXEC or LOAD.
module cu_decode
    import mycpu_pkg::*;
(
    input  logic [15:0] ir,
    input  state_t      state,
    output logic [3:0]  fs,
    output logic [2:0]  da,
    output logic [2:0]  aa,
    output logic [2:0]  ba,
    output logic        mb,
    output logic [15:0] const_val,
    output logic        md,
    output logic        rw,
    output logic        mw,
    output logic        dmem_rd
);

    class_t cls;
    assign cls = class_t'(ir[CLASS_MSB:CLASS_LSB]);

    always_comb begin
        fs        = MOVA;
        da        = 3'd0;
        aa        = 3'd0;
        ba        = 3'd0;
        mb        = 1'b0;
        const_val = 16'd0;
        md        = 1'b0;
        rw        = 1'b0;
        mw        = 1'b0;
        dmem_rd   = 1'b0;
        if (state == S_EXEC) begin
            case (cls)
                CL_ALU, CL_ALUI: begin
                    fs = ir[FS_MSB:FS_LSB];
                    da = ir[DR_MSB:DR_LSB];
                    aa = ir[SA_MSB:SA_LSB];
                    ba = ir[SB_MSB:SB_LSB];
                    rw = 1'b1;
                    if (cls == CL_ALUI) begin
                        mb        = 1'b1;
                        const_val = {13'd0, ir[SB_MSB:SB_LSB]};
                    end
                end
                CL_LD: begin
                    aa      = ir[SA_MSB:SA_LSB];
                    dmem_rd = 1'b1;
                end
                CL_ST: begin
                    aa = ir[SA_MSB:SA_LSB];
                    ba = ir[SB_MSB:SB_LSB];
                    mw = 1'b1;
                end
                default: ;
            endcase
        end else if (state == S_LOAD) begin
            // Second half of a load: write memory read data back to dr.
            da = ir[DR_MSB:DR_LSB];
            md = 1'b1;
            rw = 1'b1;
        end
    end

endmodule

// File: rtl/cu_seq.sv
// Control-unit sequencer: FETCH/DECODE/EXEC(/LOAD) state machine holding the
// PC, instruction register and registered zero/negative flags.
module cu_seq
    import mycpu_pkg::*;
#(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_in,
    output logic        imem_rd_out,
    output logic [15:0] imem_addr_out,
    input  logic [15:0] imem_data_in,
    input  logic        z_in,
    input  logic        n_in,
    output logic [3:0]  fs_out,
    output logic [2:0]  da_out,
    output logic [2:0]  aa_out,
    output logic [2:0]  ba_out,
    output logic        mb_out,
    output logic [15:0] const_out,
    output logic        md_out,
    output logic        rw_out,
    output logic        mw_out,
    output logic        dmem_rd_out,
    output logic [15:0] pc_out,
    output logic        busy_out,
    output logic        halted_out
);

    state_t      state_reg, state_next;
    logic [15:0] pc_reg, pc_next;
    logic [15:0] ir_reg;
    logic        zf_reg, nf_reg;
    logic        taken;
    class_t      cls;

    assign cls = class_t'(ir_reg[CLASS_MSB:CLASS_LSB]);

    always_comb begin
        taken = 1'b0;
        case (cls)
            CL_BRZ:  taken = zf_reg;
            CL_BRN:  taken = nf_reg;
            CL_JMP:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
        // 16-bit adds wrap naturally, covering both 16'hFFFF+1 and negative offsets.
        pc_next = pc_reg + 16'd1 + (taken ? sext_off9(ir_reg) : 16'd0);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start_in) state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                case (cls)
                    CL_LD:   state_next = S_LOAD;
                    CL_HALT: state_next = S_HALT;
                    default: state_next = S_FETCH;
                endcase
            end
            S_LOAD:   state_next = S_FETCH;
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            pc_reg    <= PC_RESET;
            ir_reg    <= 16'd0;
            zf_reg    <= 1'b0;
            nf_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            // Memory returns the word one cycle after the FETCH strobe.
            if (state_reg == S_DECODE)
                ir_reg <= imem_data_in;
            if (state_reg == S_EXEC) begin
                pc_reg <= pc_next;
                if (cls == CL_ALU || cls == CL_ALUI) begin
                    zf_reg <= z_in;
                    nf_reg <= n_in;
                end
            end
        end
    end

    cu_decode u_decode (
        .ir        (ir_reg),
        .state     (state_reg),
        .fs        (fs_out),
        .da        (da_out),
        .aa        (aa_out),
        .ba        (ba_out),
        .mb        (mb_out),
        .const_val (const_out),
        .md        (md_out),
        .rw        (rw_out),
        .mw        (mw_out),
        .dmem_rd   (dmem_rd_out)
    );

    assign imem_rd_out   = (state_reg == S_FETCH);
    assign imem_addr_out = pc_reg;
    assign pc_out        = pc_reg;
    assign busy_out      = (state_reg == S_FETCH) || (state_reg == S_DECODE) ||
                           (state_reg == S_EXEC)  || (state_reg == S_LOAD);
    assign halted_out    = (state_reg == S_HALT);

endmodule

// File: tb/tb_cu_seq.sv
// Directed bench for cu_seq: runs a short hand-assembled program against a
// 64-word instruction memory and checks every cycle of each instruction.
module tb_cu_seq;
    import mycpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic        z_in = 1'b0;
    logic        n_in = 1'b0;
    logic [15:0] imem_data_in;
    logic        imem_rd_out;
    logic [15:0] imem_addr_out;
    logic [3:0]  fs_out;
    logic [2:0]  da_out, aa_out, ba_out;
    logic        mb_out, md_out, rw_out, mw_out, dmem_rd_out;
    logic [15:0] const_out, pc_out;
    logic        busy_out, halted_out;

    logic [15:0] imem [64];
    int          n_checks = 0;
    int          n_errors = 0;

    cu_seq #(.PC_RESET(16'h0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_in      (start_in),
        .imem_rd_out   (imem_rd_out),
        .imem_addr_out (imem_addr_out),
        .imem_data_in  (imem_data_in),
        .z_in          (z_in),
        .n_in          (n_in),
        .fs_out        (fs_out),
        .da_out        (da_out),
        .aa_out        (aa_out),
        .ba_out        (ba_out),
        .mb_out        (mb_out),
        .const_out     (const_out),
        .md_out        (md_out),
        .rw_out        (rw_out),
        .mw_out        (mw_out),
        .dmem_rd_out   (dmem_rd_out),
        .pc_out        (pc_out),
        .busy_out      (busy_out),
        .halted_out    (halted_out)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory; address bits above [5:0] alias.
    always @(posedge clk) imem_data_in <= imem[imem_addr_out[5:0]];

    logic [33:0] ctl_obs;
    assign ctl_obs = {fs_out, da_out, aa_out, ba_out, mb_out, const_out,
                      md_out, rw_out, mw_out, dmem_rd_out};

    function automatic logic [33:0] ctl(input logic [3:0] fs, input logic [2:0] da,
                                        input logic [2:0] aa, input logic [2:0] ba,
                                        input logic mb, input logic [15:0] k,
                                        input logic md, input logic rw,
                                        input logic mw, input logic rd);
        return {fs, da, aa, ba, mb, k, md, rw, mw, rd};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered at the negedge where the sequencer sits in FETCH for this instruction.
    task automatic do_instr(input string tag, input logic [15:0] pc,
                            input logic [33:0] exp_ex, input bit is_ld,
                            input logic [33:0] exp_ld, input logic z, input logic n,
                            input logic [15:0] exp_pc);
        chk({tag, ".fetch"}, {imem_rd_out, busy_out, imem_addr_out, ctl_obs},
            {1'b1, 1'b1, pc, 34'd0});
        z_in = z;
        n_in = n;
        @(negedge clk);
        chk({tag, ".decode"}, {imem_rd_out, busy_out, ctl_obs}, {1'b0, 1'b1, 34'd0});
        @(negedge clk);
        chk({tag, ".exec"}, {pc_out, busy_out, ctl_obs}, {pc, 1'b1, exp_ex});
        if (is_ld) begin
            @(negedge clk);
            chk({tag, ".load"}, {pc_out, busy_out, ctl_obs}, {exp_pc, 1'b1, exp_ld});
        end
        @(negedge clk);
        chk({tag, ".pc"}, pc_out, exp_pc);
        $display("instr %-8s pc=%h -> pc=%h", tag, pc, pc_out);
    endtask

    localparam logic [33:0] NONE = 34'd0;

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 16'hE000;
        imem[0]  = 16'h0453;  // ALU  FADD dr1 sa2 sb3
        imem[1]  = 16'h40F0;  // LD   dr3 sa6
        imem[2]  = 16'hA001;  // BRN  +1 (taken -> 4)
        imem[3]  = 16'hE000;  // HALT, must be skipped
        imem[4]  = 16'h2B21;  // ALUI FSUB dr4 sa4 imm3=1
        imem[5]  = 16'h81FE;  // BRZ  -2
        imem[6]  = 16'hA005;  // BRN  +5 (not taken)
        imem[7]  = 16'h600A;  // ST   sa1 sb2
        imem[8]  = 16'hC1F6;  // JMP  -10 -> FFFF
        imem[63] = 16'hC000;  // JMP  +0 at FFFF -> 0000

        repeat (2) @(negedge clk);
        chk("reset", {busy_out, halted_out, imem_rd_out, pc_out, ctl_obs}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_wait", {busy_out, halted_out, imem_rd_out}, 3'b000);
        start_in = 1'b1;  // left high: must be ignored outside IDLE
        @(negedge clk);

        do_instr("alu", 16'h0000, ctl(FADD, 3'd1, 3'd2, 3'd3, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0),
                 1'b0, NONE, 1'b0, 1'b1, 16'h0001);
        imem[0] = 16'hE000;
        do_instr("ld", 16'h0001, ctl(MOVA, 3'd0, 3'd6, 3'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b1),
                 1'b1, ctl(MOVA, 3'd3, 3'd0, 3'd0, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0),
                 1'b1, 1'b0, 16'h0002);
        do_instr("brn_t", 16'h0002, NONE, 1'b0, NONE, 1'b0, 1'b0, 16'h0004);
        do_instr("alui", 16'h0004, ctl(FSUB, 3'd4, 3'd4, 3'd1, 1'b1, 16'd1, 1'b0, 1'b1, 1'b0, 1'b0),
                 1'b0, NONE, 1'b1, 1'b0, 16'h0005);
        do_instr("brz_t", 16'h0005, NONE, 1'b0, NONE, 1'b0, 1'b0, 16'h0004);
        do_instr("alui2", 16'h0004, ctl(FSUB, 3'd4, 3'd4, 3'd1, 1'b1, 16'd1, 1'b0, 1'b1, 1'b0, 1'b0),
                 1'b0, NONE, 1'b0, 1'b0, 16'h0005);
        do_instr("brz_n", 16'h0005, NONE, 1'b0, NONE, 1'b1, 1'b1, 16'h0006);
        do_instr("brn_n", 16'h0006, NONE, 1'b0, NONE, 1'b0, 1'b0, 16'h0007);
        do_instr("st", 16'h0007, ctl(MOVA, 3'd0, 3'd1, 3'd2, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0),
                 1'b0, NONE, 1'b1, 1'b1, 16'h0008);
        do_instr("jmp_neg", 16'h0008, NONE, 1'b0, NONE, 1'b0, 1'b0, 16'hFFFF);
        do_instr("jmp_wrap", 16'hFFFF, NONE, 1'b0, NONE, 1'b0, 1'b0, 16'h0000);
        do_instr("halt", 16'h0000, NONE, 1'b0, NONE, 1'b0, 1'b0, 16'h0001);

        chk("halted", {busy_out, halted_out, imem_rd_out}, 3'b010);
        repeat (3) @(negedge clk);
        chk("halt_hold", {busy_out, halted_out, imem_rd_out, pc_out, ctl_obs},
            {1'b0, 1'b1, 1'b0, 16'h0001, 34'd0});
        $display("halt start_in ignored pc=%h", pc_out);

        // Asynchronous reset landing in the middle of a store's EXEC cycle.
        rst_n = 1'b0;
        #1;
        chk("rst_from_halt", {halted_out, pc_out}, 0);
        imem[0] = 16'h600A;
        @(negedge clk);
        rst_n = 1'b1;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        chk("st2.fetch", {imem_rd_out, imem_addr_out}, {1'b1, 16'h0000});
        @(negedge clk);
        @(negedge clk);
        chk("st2.exec", {mw_out, aa_out, ba_out}, {1'b1, 3'd1, 3'd2});
        #2;
        rst_n = 1'b0;
        #1;
        chk("st2.abort", {mw_out, rw_out, busy_out, halted_out, pc_out}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_idle", {mw_out, rw_out, busy_out, imem_rd_out, pc_out}, 0);
        end
        $display("reset abort of store, idle after release");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cu_seq.md
CU_SEQ -- requirements
Module: cu_seq

Interface
REQ-001 Parameter: PC_RESET, 16'h0000, PC value loaded on reset.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-004 start_in  in  1  begin execution from PC; sampled in IDLE only.
REQ-005 imem_rd_out  out  1  instruction-memory read strobe.
REQ-006 imem_addr_out  out  16  instruction address; equals PC.
REQ-007 imem_data_in  in  16  instruction word, valid the cycle after imem_rd_out.
REQ-008 z_in, n_in  in  1 each  function-unit zero and negative flags.
REQ-009 fs_out  out  4  function-unit select (fs_t encoding).
REQ-010 da_out, aa_out, ba_out  out  3 each  destination, A and B register addresses.
REQ-011 mb_out  out  1  1 selects const_out as the B operand.
REQ-012 const_out  out  16  zero-extended immediate.
REQ-013 md_out  out  1  1 selects data-memory read data for write-back.
REQ-014 rw_out, mw_out, dmem_rd_out  out  1 each  register write, data-memory write and data-memory read strobes.
REQ-015 pc_out  out  16  current PC; busy_out, halted_out  out  1 each  state indicators.

Function
REQ-016 Instruction fields SHALL be: [15:13] class, [12:9] fs, [8:6] dr, [5:3] sa, [2:0] sb/imm3; branch offset = sign-extended [8:0].
REQ-017 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC, LOAD and HALT.
REQ-018 IDLE→FETCH on start_in=1; FETCH→DECODE; DECODE→EXEC, with IR captured from imem_data_in.
REQ-019 EXEC→LOAD for class LD; EXEC→HALT for class HALT; EXEC→FETCH otherwise; LOAD→FETCH; HALT SHALL persist until reset.
REQ-020 FETCH SHALL assert imem_rd_out=1 with imem_addr_out=PC for exactly one cycle.
REQ-021 Class 000 ALU: in EXEC, fs=IR.fs, da=dr, aa=sa, ba=sb, mb=0, rw=1.
REQ-022 Class 001 ALUI: as ALU, but mb=1 and const_out={13'b0, imm3}.
REQ-023 Class 010 LD: EXEC drives aa=sa, fs=MOVA and dmem_rd=1; LOAD drives da=dr, md=1 and rw=1.
REQ-024 Class 011 ST: EXEC drives aa=sa, ba=sb, mb=0 and mw=1.
REQ-025 Class 100 BRZ: taken if zf=1; class 101 BRN: taken if nf=1; class 110 JMP: always taken.
REQ-026 A taken branch SHALL set PC←PC+1+sext(off9); every other instruction SHALL set PC←PC+1; the update SHALL occur at the end of EXEC.
REQ-027 PC arithmetic SHALL be 16-bit modulo: 16'hFFFF+1=16'h0000, and negative offsets wrap likewise.
REQ-028 Registered flags zf/nf SHALL load z_in/n_in at the end of EXEC for the ALU and ALUI classes only; other classes hold them.
REQ-029 Outside EXEC/LOAD, all strobes (rw, mw, dmem_rd, md, mb) SHALL be 0, fs=MOVA (4'h0), and the addresses/const SHALL be 0.
REQ-030 Each strobe SHALL be high for exactly one cycle per instruction.
REQ-031 start_in SHALL be ignored outside IDLE.
REQ-032 busy_out SHALL be 1 in FETCH, DECODE, EXEC and LOAD.
REQ-033 halted_out SHALL be 1 only in HALT.
REQ-034 Latency SHALL be 3 cycles per instruction, and 4 cycles for LD.

Reset
REQ-035 rst_n=0 SHALL immediately force state=IDLE, PC=PC_RESET, IR=0 and zf=nf=0, with all strobes 0, independent of clk.
REQ-036 Reset mid-instruction SHALL abort the instruction: no pending rw/mw is issued after release.
REQ-037 After release, the block SHALL wait in IDLE for start_in.

Structure
REQ-038 The state enum, the instruction-class enum and the field bit positions SHALL live in mycpu_pkg, alongside the existing fs_t.
REQ-039 Combinational field decode SHALL be one sub-module, cu_decode (IR and state in, control outputs out); cu_seq holds the FSM, PC, IR and flags.

Verification
REQ-040 Reset, then start_in=1: imem_rd_out=1 with imem_addr_out=16'h0000 one cycle later; pc_out=1 after EXEC.
REQ-041 IR=16'h0453 (ALU, fs=4'h2 FADD, dr=1, sa=2, sb=3) → in EXEC: fs_out=2, da=1, aa=2, ba=3, mb=0, rw=1 for one cycle.
REQ-042 ALUI with fs=FSUB, dr=4, sa=4, imm3=1, and z_in=1 in EXEC; then BRZ with off9=9'h1FE at PC=5 → PC becomes 16'h0004.
REQ-043 LD with dr=3, sa=6 → EXEC: dmem_rd=1, aa=6; next cycle LOAD: md=1, rw=1, da=3; 4 cycles total.
REQ-044 JMP at PC=16'hFFFF with off9=0 → PC=16'h0000.
REQ-045 HALT then start_in=1 → remains halted; rst_n low during EXEC of ST → mw_out=0 immediately, state=IDLE.
